// File: rtl/intc_pkg.sv
// intc_pkg: shared types and constants for the interrupt sequencer.
package intc_pkg;
    localparam int VEC_W = 8;
    localparam logic [VEC_W-1:0] NMI_VECTOR = 8'd7;
    localparam logic [2:0] NMI_PRIORITY = 3'd7;
    localparam logic [1:0] INTM_PRIO = 2'b10;
    typedef enum logic [1:0] {IDLE, REQ, ACK, HOLD} state_t;
endpackage

// File: rtl/intc_priority_resolver.sv
// intc_priority_resolver: picks the winning eligible pending source.
module intc_priority_resolver #(
    parameter int NUM_SRC = 240,
    parameter int IDX_W = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]      pending,
    input  logic [NUM_SRC-1:0]      elig,
    input  logic [NUM_SRC-1:0][2:0] prio,
    input  logic                    prio_mode,
    output logic                    valid,
    output logic [IDX_W-1:0]        idx,
    output logic [2:0]              level
);
    // Scanning downward with >= lets the lowest index win every tie.
    always_comb begin
        valid = 1'b0;
        idx = '0;
        level = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (pending[i] && elig[i] && (!valid || !prio_mode || prio[i] >= level)) begin
                valid = 1'b1;
                idx = IDX_W'(i);
                level = prio[i];
            end
    end
endmodule

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: pending capture, NMI, request/ack handshake and post-ack hold-off.
module interrupt_sequencer
    import intc_pkg::*;
#(
    parameter int NUM_SRC = 240,
    parameter int VEC_BASE = 16,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_SRC-1:0]      irq_in,
    input  logic [NUM_SRC-1:0]      edge_sel,
    input  logic [NUM_SRC-1:0][2:0] src_priority,
    input  logic                    nmi_in,
    input  logic [1:0]              intm,
    input  logic                    ccr_i,
    input  logic [2:0]              exr,
    input  logic                    cpu_ack,
    output logic                    int_req,
    output logic [VEC_W-1:0]        vector,
    output logic [2:0]              max_priority,
    output logic                    ack_valid,
    output logic [VEC_W-1:0]        ack_vector
);
    localparam int IDX_W = $clog2(NUM_SRC);
    state_t state, state_n;
    logic [NUM_SRC-1:0] pending, edge_hist, elig, clr;
    logic nmi_pend, nmi_hist, prio_mode, win_valid, any_win, ack_take;
    logic cur_nmi, cur_nmi_n, ack_nmi, int_req_n;
    logic [IDX_W-1:0] win_idx, cur_idx, cur_idx_n, ack_idx;
    logic [2:0] win_prio, win_p, max_priority_n;
    logic [VEC_W-1:0] win_vec, vector_n;
    logic [3:0] hold_cnt, hold_cnt_n;
    assign prio_mode = intm == INTM_PRIO;
    assign any_win = nmi_pend | win_valid;
    assign win_vec = nmi_pend ? NMI_VECTOR : VEC_W'(VEC_BASE) + VEC_W'(win_idx);
    assign win_p = nmi_pend ? NMI_PRIORITY : win_prio;
    assign ack_take = state == REQ && cpu_ack;
    always_comb begin
        elig = '0;
        clr = '0;
        for (int i = 0; i < NUM_SRC; i++) elig[i] = prio_mode ? src_priority[i] > exr : !ccr_i;
        if (state == ACK && !ack_nmi) clr[ack_idx] = 1'b1;
    end
    intc_priority_resolver #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_resolver (
        .pending(pending),
        .elig(elig),
        .prio(src_priority),
        .prio_mode(prio_mode),
        .valid(win_valid),
        .idx(win_idx),
        .level(win_prio)
    );
    // Outputs are rebuilt every cycle in REQ so a stronger winner preempts before the ack.
    always_comb begin
        state_n = state;
        int_req_n = 1'b0;
        vector_n = '0;
        max_priority_n = '0;
        cur_idx_n = cur_idx;
        cur_nmi_n = cur_nmi;
        hold_cnt_n = hold_cnt;
        case (state)
            IDLE, REQ: begin
                if (ack_take) state_n = ACK;
                else if (any_win) begin
                    state_n = REQ;
                    int_req_n = 1'b1;
                    vector_n = win_vec;
                    max_priority_n = win_p;
                    cur_idx_n = win_idx;
                    cur_nmi_n = nmi_pend;
                end else state_n = IDLE;
            end
            ACK: begin
                state_n = HOLD;
                hold_cnt_n = 4'(HOLD_CYCLES);
            end
            default: begin
                hold_cnt_n = hold_cnt - 4'd1;
                state_n = hold_cnt <= 4'd1 ? IDLE : HOLD;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pending <= '0;
            edge_hist <= '0;
            nmi_pend <= 1'b0;
            nmi_hist <= 1'b0;
            int_req <= 1'b0;
            vector <= '0;
            max_priority <= '0;
            ack_valid <= 1'b0;
            ack_vector <= '0;
            ack_idx <= '0;
            ack_nmi <= 1'b0;
            cur_idx <= '0;
            cur_nmi <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state <= state_n;
            edge_hist <= irq_in;
            nmi_hist <= nmi_in;
            pending <= (edge_sel & ((pending & ~clr) | (irq_in & ~edge_hist))) | (~edge_sel & irq_in);
            nmi_pend <= (nmi_pend & !(state == ACK && ack_nmi)) | (nmi_in & !nmi_hist);
            int_req <= int_req_n;
            vector <= vector_n;
            max_priority <= max_priority_n;
            ack_valid <= ack_take;
            ack_vector <= ack_take ? vector : '0;
            if (ack_take) begin
                ack_idx <= cur_idx;
                ack_nmi <= cur_nmi;
            end
            cur_idx <= cur_idx_n;
            cur_nmi <= cur_nmi_n;
            hold_cnt <= hold_cnt_n;
        end
    end
endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: scoreboard-driven checks of prioritisation and the ack handshake.
module tb_interrupt_sequencer;
    localparam int NUM_SRC = 240;
    typedef struct {
        logic [7:0] v;
        logic [2:0] p;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NUM_SRC-1:0] irq_in = '0;
    logic [NUM_SRC-1:0] edge_sel = '0;
    logic [NUM_SRC-1:0][2:0] src_priority = '0;
    logic nmi_in = 1'b0;
    logic [1:0] intm = 2'b00;
    logic ccr_i = 1'b0;
    logic [2:0] exr = 3'd0;
    logic cpu_ack = 1'b0;
    logic int_req, ack_valid;
    logic [7:0] vector, ack_vector;
    logic [2:0] max_priority;
    int errors = 0;
    int checks = 0;
    exp_t q[$];

    interrupt_sequencer #(.NUM_SRC(NUM_SRC), .VEC_BASE(16), .HOLD_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .edge_sel(edge_sel),
        .src_priority(src_priority), .nmi_in(nmi_in), .intm(intm), .ccr_i(ccr_i),
        .exr(exr), .cpu_ack(cpu_ack), .int_req(int_req), .vector(vector),
        .max_priority(max_priority), .ack_valid(ack_valid), .ack_vector(ack_vector)
    );

    always #5 clk = ~clk;

    task tick;
        @(negedge clk);
    endtask

    task pulse(input int i);
        irq_in[i] = 1'b1;
        tick();
        irq_in[i] = 1'b0;
    endtask

    task push(input logic [7:0] v, input logic [2:0] p);
        exp_t e;
        e.v = v;
        e.p = p;
        q.push_back(e);
    endtask

    task ack_and_check;
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL ack_scoreboard_empty int_req=%0b vector=%0d", int_req, vector);
            return;
        end
        e = q.pop_front();
        checks++;
        if (int_req !== 1'b1 || vector !== e.v || max_priority !== e.p) begin
            errors++;
            $display("FAIL present got req=%0b vec=%0d prio=%0d want req=1 vec=%0d prio=%0d",
                     int_req, vector, max_priority, e.v, e.p);
        end
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
        checks++;
        if (ack_valid !== 1'b1 || ack_vector !== e.v || int_req !== 1'b0) begin
            errors++;
            $display("FAIL ack got valid=%0b vec=%0d req=%0b want valid=1 vec=%0d req=0",
                     ack_valid, ack_vector, int_req, e.v);
        end
    endtask

    task check_rereq;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (int_req !== 1'b0 || ack_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold cycle %0d got req=%0b ack_valid=%0b want 0 0", k, int_req, ack_valid);
            end
        end
        tick();
        checks++;
        if (q.size() > 0) begin
            if (int_req !== 1'b1 || vector !== q[0].v || max_priority !== q[0].p) begin
                errors++;
                $display("FAIL rereq got req=%0b vec=%0d prio=%0d want req=1 vec=%0d prio=%0d",
                         int_req, vector, max_priority, q[0].v, q[0].p);
            end
        end else if (int_req !== 1'b0) begin
            errors++;
            $display("FAIL rereq_idle got req=%0b vec=%0d want req=0", int_req, vector);
        end
    endtask

    task test_reset;
        tick();
        tick();
        checks++;
        if ({int_req, vector, max_priority, ack_valid, ack_vector} !== '0) begin
            errors++;
            $display("FAIL reset got req=%0b vec=%0d prio=%0d av=%0b avec=%0d want all 0",
                     int_req, vector, max_priority, ack_valid, ack_vector);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task test_edge_ack;
        intm = 2'b10;
        exr = 3'd3;
        edge_sel[5] = 1'b1;
        src_priority[5] = 3'd4;
        pulse(5);
        checks++;
        if (int_req !== 1'b0) begin
            errors++;
            $display("FAIL edge_latency got req=%0b want 0", int_req);
        end
        push(8'd21, 3'd4);
        tick();
        ack_and_check();
        check_rereq();
    endtask

    task test_prio_tie;
        edge_sel[2] = 1'b1;
        edge_sel[10] = 1'b1;
        edge_sel[30] = 1'b1;
        src_priority[2] = 3'd5;
        src_priority[10] = 3'd5;
        src_priority[30] = 3'd6;
        irq_in[2] = 1'b1;
        irq_in[10] = 1'b1;
        irq_in[30] = 1'b1;
        push(8'd46, 3'd6);
        push(8'd18, 3'd5);
        push(8'd26, 3'd5);
        tick();
        irq_in = '0;
        tick();
        ack_and_check();
        check_rereq();
        ack_and_check();
        check_rereq();
        ack_and_check();
        check_rereq();
    endtask

    task test_exr_mask;
        exr = 3'd6;
        irq_in[2] = 1'b1;
        irq_in[10] = 1'b1;
        irq_in[30] = 1'b1;
        tick();
        irq_in = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (int_req !== 1'b0) begin
                errors++;
                $display("FAIL exr6_masked cycle %0d got req=%0b want 0", k, int_req);
            end
        end
        exr = 3'd5;
        push(8'd46, 3'd6);
        tick();
        ack_and_check();
        check_rereq();
        exr = 3'd4;
        push(8'd18, 3'd5);
        push(8'd26, 3'd5);
        tick();
        ack_and_check();
        check_rereq();
        ack_and_check();
        check_rereq();
    endtask

    task test_nmi_preempt;
        exr = 3'd3;
        edge_sel[3] = 1'b1;
        src_priority[3] = 3'd4;
        pulse(3);
        tick();
        checks++;
        if (int_req !== 1'b1 || vector !== 8'd19) begin
            errors++;
            $display("FAIL src3_req got req=%0b vec=%0d want 1 19", int_req, vector);
        end
        nmi_in = 1'b1;
        push(8'd7, 3'd7);
        push(8'd19, 3'd4);
        tick();
        nmi_in = 1'b0;
        checks++;
        if (int_req !== 1'b1 || vector !== 8'd19) begin
            errors++;
            $display("FAIL nmi_latency got req=%0b vec=%0d want 1 19", int_req, vector);
        end
        tick();
        ack_and_check();
        check_rereq();
        ack_and_check();
        check_rereq();
    endtask

    task test_mode0;
        intm = 2'b00;
        exr = 3'd0;
        ccr_i = 1'b0;
        src_priority[0] = 3'd1;
        src_priority[4] = 3'd7;
        irq_in[0] = 1'b1;
        irq_in[4] = 1'b1;
        tick();
        tick();
        checks++;
        if (int_req !== 1'b1 || vector !== 8'd16 || max_priority !== 3'd1) begin
            errors++;
            $display("FAIL mode0_lowest got req=%0b vec=%0d prio=%0d want 1 16 1",
                     int_req, vector, max_priority);
        end
        irq_in[0] = 1'b0;
        irq_in[4] = 1'b0;
        tick();
        checks++;
        if (int_req !== 1'b1) begin
            errors++;
            $display("FAIL level_hold got req=%0b want 1", int_req);
        end
        tick();
        checks++;
        if (int_req !== 1'b0 || vector !== 8'd0 || max_priority !== 3'd0) begin
            errors++;
            $display("FAIL level_drop got req=%0b vec=%0d prio=%0d want 0 0 0",
                     int_req, vector, max_priority);
        end
        ccr_i = 1'b1;
        irq_in[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (int_req !== 1'b0) begin
                errors++;
                $display("FAIL ccr_masked cycle %0d got req=%0b want 0", k, int_req);
            end
        end
        nmi_in = 1'b1;
        push(8'd7, 3'd7);
        tick();
        nmi_in = 1'b0;
        tick();
        ack_and_check();
        check_rereq();
        irq_in[0] = 1'b0;
        ccr_i = 1'b0;
        tick();
        tick();
    endtask

    task test_reset_mid;
        intm = 2'b10;
        exr = 3'd0;
        edge_sel[7] = 1'b1;
        src_priority[7] = 3'd3;
        pulse(7);
        push(8'd23, 3'd3);
        tick();
        ack_and_check();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({int_req, vector, max_priority, ack_valid, ack_vector} !== '0) begin
            errors++;
            $display("FAIL reset_mid got req=%0b vec=%0d prio=%0d av=%0b avec=%0d want all 0",
                     int_req, vector, max_priority, ack_valid, ack_vector);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (int_req !== 1'b0) begin
                errors++;
                $display("FAIL post_reset cycle %0d got req=%0b want 0", k, int_req);
            end
        end
        pulse(7);
        push(8'd23, 3'd3);
        tick();
        ack_and_check();
        check_rereq();
    endtask

    initial begin
        test_reset();
        test_edge_ack();
        test_prio_tie();
        test_exr_mask();
        test_nmi_preempt();
        test_mode0();
        test_reset_mid();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
